// File: rtl/topaz_spi_master.sv
// Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// One transfer per valid/ready handshake; the received word is returned with a one-cycle rx_valid pulse.
module topaz_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic              sys_clk,
    input  logic              cpu_rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              cs_hold,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_cs_n
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BITS_ONE  = BIT_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [DIV_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bits;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_rx_sh;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_sck;
    logic              r_mosi;
    logic              r_cs_n;
    logic              w_accept;
    logic              w_tick;
    logic              w_rise;
    logic              w_fall;
    logic              w_done;
    logic [DATA_W-1:0] w_tx_shift;

    assign w_tx_shift = r_tx_sh << 1'b1;

    // State register
    always_ff @(posedge sys_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus SCK edge strobes derived from the half-period divider
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_tick       = 1'b0;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = tx_valid;
                if (tx_valid) begin
                    w_next_state = ST_XFER;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_XFER: begin
                w_tick = (r_div == DIV_LAST);
                w_rise = w_tick && !r_sck;
                w_fall = w_tick && r_sck;
                w_done = w_fall && (r_bits == BITS_LAST);
                if (w_done) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_XFER;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: divider, shifters, pin registers and the completion pulse
    always_ff @(posedge sys_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_div      <= '0;
            r_bits     <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_accept) begin
                r_tx_sh <= tx_data;
                r_mosi  <= tx_data[DATA_W-1];
                r_cs_n  <= 1'b0;
                r_sck   <= 1'b0;
                r_div   <= '0;
                r_bits  <= '0;
            end else if (r_state == ST_XFER) begin
                if (w_tick) begin
                    r_div <= '0;
                    r_sck <= !r_sck;
                end else begin
                    r_div <= r_div + DIV_ONE;
                end
                // MISO is sampled on the same sys_clk edge that raises SCK
                if (w_rise) begin
                    r_rx_sh <= {r_rx_sh[DATA_W-2:0], spi_miso};
                end
                if (w_fall) begin
                    r_bits <= r_bits + BITS_ONE;
                    if (w_done) begin
                        r_rx_data  <= r_rx_sh;
                        r_rx_valid <= 1'b1;
                        r_cs_n     <= !cs_hold;
                    end else begin
                        r_tx_sh <= w_tx_shift;
                        r_mosi  <= w_tx_shift[DATA_W-1];
                    end
                end
            end else if (!cs_hold) begin
                // A held chip select is released as soon as cs_hold drops in IDLE
                r_cs_n <= 1'b1;
            end
        end
    end

    assign tx_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign spi_sck  = r_sck;
    assign spi_mosi = r_mosi;
    assign spi_cs_n = r_cs_n;

endmodule

// File: tb/tb_topaz_spi_master.sv
// Self-checking bench for topaz_spi_master: a CLK_DIV=4 instance driven by a behavioural SPI slave
// or loopback, and a CLK_DIV=1 loopback instance.
module tb_topaz_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] a_tx_data, a_rx_data, b_tx_data, b_rx_data;
    logic       a_tx_valid, a_tx_ready, a_cs_hold, a_rx_valid, a_busy, a_sck, a_mosi, a_miso, a_cs_n;
    logic       b_tx_valid, b_tx_ready, b_cs_hold, b_rx_valid, b_busy, b_sck, b_mosi, b_miso, b_cs_n;
    logic       a_loop, a_slave_bit;
    logic       exp_cs_low;
    int         n_chk = 0;
    int         n_err = 0;

    assign a_miso = a_loop ? a_mosi : a_slave_bit;
    assign b_miso = b_mosi;

    topaz_spi_master #(.CLK_DIV(4), .DATA_W(8)) dut_a (
        .sys_clk(clk), .cpu_rst(rst_n), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
        .tx_ready(a_tx_ready), .cs_hold(a_cs_hold), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
        .busy(a_busy), .spi_sck(a_sck), .spi_mosi(a_mosi), .spi_miso(a_miso), .spi_cs_n(a_cs_n)
    );

    topaz_spi_master #(.CLK_DIV(1), .DATA_W(8)) dut_b (
        .sys_clk(clk), .cpu_rst(rst_n), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
        .tx_ready(b_tx_ready), .cs_hold(b_cs_hold), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
        .busy(b_busy), .spi_sck(b_sck), .spi_mosi(b_mosi), .spi_miso(b_miso), .spi_cs_n(b_cs_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transfer on the CLK_DIV=4 instance. The slave shifts sb out MSB first, changing
    // MISO after each SCK fall; with loop=1 MOSI is wired back to MISO instead.
    task automatic xfer_a(input logic [7:0] d, input logic hold, input logic [7:0] sb,
                          input logic loop, input logic keep, input int gap, input int abort_at);
        int         cyc;
        int         rises;
        int         last_rise;
        int         cs_low;
        int         sidx;
        logic       prev_sck;
        logic       bad_spacing;
        logic       bad_busy;
        logic [7:0] mosi_cap;
        logic [7:0] exp_rx;
        if (gap > 0) a_tx_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check_eq("idle_cs_n", a_cs_n, !exp_cs_low);
            check_eq("idle_sck", a_sck, 1'b0);
        end
        @(negedge clk);
        a_tx_data   = d;
        a_tx_valid  = 1'b1;
        a_cs_hold   = hold;
        a_loop      = loop;
        sidx        = 0;
        a_slave_bit = sb[7];
        exp_rx      = loop ? d : sb;
        check_eq("ready_idle", a_tx_ready, 1'b1);
        @(posedge clk);
        #1;
        check_eq("acc_rx_valid", a_rx_valid, 1'b0);
        check_eq("acc_cs_n", a_cs_n, 1'b0);
        check_eq("acc_mosi", a_mosi, d[7]);
        a_tx_data  = ~d;
        a_tx_valid = keep;
        cyc = 0; rises = 0; last_rise = 0; cs_low = 0;
        prev_sck = 1'b0; bad_spacing = 1'b0; bad_busy = 1'b0; mosi_cap = 8'h00;
        while (!a_rx_valid && cyc < 300) begin
            if (abort_at > 0 && cyc == abort_at) begin
                #1;
                rst_n = 1'b0;
                #1;
                check_eq("abort_sck", a_sck, 1'b0);
                check_eq("abort_cs_n", a_cs_n, 1'b1);
                check_eq("abort_ready", a_tx_ready, 1'b1);
                check_eq("abort_busy", a_busy, 1'b0);
                check_eq("abort_rx_data", a_rx_data, 8'h00);
                a_tx_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                rises = 0;
                for (int k = 0; k < 80; k++) begin
                    @(posedge clk);
                    #1;
                    if (a_rx_valid) rises++;
                end
                check_eq("abort_no_rx", rises, 0);
                exp_cs_low = 1'b0;
                return;
            end
            if (!a_cs_n) cs_low++;
            if (!a_busy || a_tx_ready) bad_busy = 1'b1;
            if (a_sck && !prev_sck) begin
                rises++;
                mosi_cap = {mosi_cap[6:0], a_mosi};
                if (rises > 1 && (cyc - last_rise) != 8) bad_spacing = 1'b1;
                last_rise = cyc;
            end
            if (!a_sck && prev_sck) begin
                sidx++;
                if (sidx < 8) a_slave_bit = sb[7-sidx];
            end
            prev_sck = a_sck;
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("latency", cyc, 64);
        check_eq("rx_data", a_rx_data, exp_rx);
        check_eq("sck_rises", rises, 8);
        check_eq("sck_period", bad_spacing, 1'b0);
        check_eq("busy_in_xfer", bad_busy, 1'b0);
        check_eq("cs_low_cycles", cs_low, 64);
        check_eq("mosi_bits", mosi_cap, d);
        check_eq("done_cs_n", a_cs_n, !hold);
        check_eq("done_sck", a_sck, 1'b0);
        check_eq("done_ready", a_tx_ready, 1'b1);
        exp_cs_low = hold;
    endtask

    // Loopback transfer on the CLK_DIV=1 instance: SCK must toggle on every cycle of the transfer.
    task automatic xfer_b(input logic [7:0] d);
        int   cyc;
        logic prev;
        logic bad_tog;
        @(negedge clk);
        b_tx_data  = d;
        b_tx_valid = 1'b1;
        @(posedge clk);
        #1;
        b_tx_valid = 1'b0;
        b_tx_data  = ~d;
        cyc = 0; prev = b_sck; bad_tog = 1'b0;
        while (!b_rx_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (b_sck == prev) bad_tog = 1'b1;
            prev = b_sck;
        end
        check_eq("b_latency", cyc, 16);
        check_eq("b_rx_data", b_rx_data, d);
        check_eq("b_sck_toggle", bad_tog, 1'b0);
        check_eq("b_cs_n", b_cs_n, 1'b1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic [7:0] sb;
        rst_n = 1'b0;
        a_tx_data = 8'h00; a_tx_valid = 1'b0; a_cs_hold = 1'b0; a_loop = 1'b1; a_slave_bit = 1'b0;
        b_tx_data = 8'h00; b_tx_valid = 1'b0; b_cs_hold = 1'b0;
        exp_cs_low = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_sck", a_sck, 1'b0);
        check_eq("rst_mosi", a_mosi, 1'b0);
        check_eq("rst_cs_n", a_cs_n, 1'b1);
        check_eq("rst_ready", a_tx_ready, 1'b1);
        check_eq("rst_busy", a_busy, 1'b0);
        check_eq("rst_rx_valid", a_rx_valid, 1'b0);
        check_eq("rst_rx_data", a_rx_data, 8'h00);
        check_eq("rst_b_cs_n", b_cs_n, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        xfer_a(8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 2, 0);
        xfer_a(8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1, 0);

        // Back-to-back with chip select held, then release by dropping cs_hold
        xfer_a(8'h12, 1'b1, 8'h00, 1'b1, 1'b0, 1, 0);
        xfer_a(8'h34, 1'b1, 8'h00, 1'b1, 1'b0, 0, 0);
        @(negedge clk);
        check_eq("hold_cs_n", a_cs_n, 1'b0);
        a_cs_hold = 1'b0;
        @(posedge clk);
        #1;
        check_eq("release_cs_n", a_cs_n, 1'b1);
        exp_cs_low = 1'b0;

        xfer_a(8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1, 30);
        xfer_a(8'hC3, 1'b0, 8'h00, 1'b1, 1'b0, 1, 0);

        // tx_valid held high with changing tx_data throughout
        xfer_a(8'h69, 1'b0, 8'h0F, 1'b0, 1'b1, 1, 0);
        xfer_a(8'h81, 1'b0, 8'hE7, 1'b0, 1'b1, 0, 0);
        xfer_a(8'hF0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            d  = 8'($urandom_range(0, 255));
            sb = 8'($urandom_range(0, 255));
            xfer_a(d, 1'($urandom_range(0, 1)), sb, 1'($urandom_range(0, 1)), 1'b0,
                   $urandom_range(0, 3), 0);
        end

        xfer_b(8'h3C);
        for (int i = 0; i < 3; i++) begin
            xfer_b(8'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
